// File: rtl/dma_copy.sv
// dma_copy: single-channel word-copy DMA engine with a register port for
// programming and a single-outstanding bus-host port for the copy itself.
module dma_copy #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_req_i,
  input  logic                    cfg_we_i,
  input  logic [3:0]              cfg_be_i,
  input  logic [AddressWidth-1:0] cfg_addr_i,
  input  logic [DataWidth-1:0]    cfg_wdata_i,
  output logic                    cfg_rvalid_o,
  output logic [DataWidth-1:0]    cfg_rdata_o,
  output logic                    cfg_err_o,
  output logic                    host_req_o,
  input  logic                    host_gnt_i,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [DataWidth-1:0]    host_wdata_o,
  input  logic                    host_rvalid_i,
  input  logic [DataWidth-1:0]    host_rdata_i,
  input  logic                    host_err_i,
  output logic                    dma_intr_o
);

  localparam int unsigned LenWidth = 16;

  localparam logic [2:0] OffSrc    = 3'd0;
  localparam logic [2:0] OffDst    = 3'd1;
  localparam logic [2:0] OffLen    = 3'd2;
  localparam logic [2:0] OffCtrl   = 3'd3;
  localparam logic [2:0] OffStatus = 3'd4;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [AddressWidth-1:0] wsrc_q, wsrc_d, wdst_q, wdst_d;
  logic [LenWidth-1:0]     len_q, len_d, cnt_q, cnt_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic                    ie_q, ie_d, done_q, done_d, err_q, err_d;
  logic                    rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic [2:0]              off;
  logic                    mapped, busy, start;
  logic                    unused_addr;

  assign off         = cfg_addr_i[4:2];
  assign mapped      = (off <= OffStatus);
  assign busy        = (state_q != IDLE);
  assign unused_addr = ^{cfg_addr_i[AddressWidth-1:5], cfg_addr_i[1:0]};

  // Byte-enable merge of register write data into an existing value
  function automatic logic [DataWidth-1:0] be_merge(input logic [DataWidth-1:0] old_v,
                                                    input logic [DataWidth-1:0] new_v,
                                                    input logic [3:0]           be);
    be_merge = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) be_merge[i*8 +: 8] = new_v[i*8 +: 8];
    end
  endfunction

  // Register decode, copy FSM next state, and datapath next values
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    wsrc_d   = wsrc_q;
    wdst_d   = wdst_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    ie_d     = ie_q;
    done_d   = done_q;
    err_d    = err_q;
    rvalid_d = cfg_req_i;
    rerr_d   = cfg_req_i & ~mapped;
    rdata_d  = '0;
    start    = 1'b0;

    if (cfg_req_i && mapped) begin
      if (cfg_we_i) begin
        case (off)
          OffSrc: if (!busy) begin
            src_d      = AddressWidth'(be_merge(DataWidth'(src_q), cfg_wdata_i, cfg_be_i));
            src_d[1:0] = 2'b00;
          end
          OffDst: if (!busy) begin
            dst_d      = AddressWidth'(be_merge(DataWidth'(dst_q), cfg_wdata_i, cfg_be_i));
            dst_d[1:0] = 2'b00;
          end
          OffLen: if (!busy) begin
            len_d = LenWidth'(be_merge(DataWidth'(len_q), cfg_wdata_i, cfg_be_i));
          end
          OffCtrl: if (cfg_be_i[0]) begin
            ie_d  = cfg_wdata_i[1];
            start = cfg_wdata_i[0] & ~busy;
          end
          OffStatus: if (cfg_be_i[0]) begin
            if (cfg_wdata_i[1]) done_d = 1'b0;
            if (cfg_wdata_i[2]) err_d  = 1'b0;
          end
          default: ;
        endcase
      end else begin
        case (off)
          OffSrc:    rdata_d = DataWidth'(src_q);
          OffDst:    rdata_d = DataWidth'(dst_q);
          OffLen:    rdata_d = DataWidth'(len_q);
          OffCtrl:   rdata_d = DataWidth'({ie_q, 1'b0});
          OffStatus: rdata_d = DataWidth'({err_q, done_q, busy});
          default:   rdata_d = '0;
        endcase
      end
    end

    // Hardware updates come after the W1C so a same-cycle set wins
    case (state_q)
      IDLE: if (start) begin
        if (len_q != '0) begin
          wsrc_d  = src_q;
          wdst_d  = dst_q;
          cnt_d   = len_q;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = RD_REQ;
        end else begin
          done_d = 1'b1;
        end
      end
      RD_REQ: if (host_gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (host_rvalid_i) begin
        if (host_err_i) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          data_d  = host_rdata_i;
          state_d = WR_REQ;
        end
      end
      WR_REQ: if (host_gnt_i) state_d = WR_WAIT;
      WR_WAIT: if (host_rvalid_i) begin
        if (host_err_i) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wsrc_d = wsrc_q + AddressWidth'(4);
          wdst_d = wdst_q + AddressWidth'(4);
          cnt_d  = cnt_q - LenWidth'(1);
          if (cnt_q == LenWidth'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      wsrc_q   <= '0;
      wdst_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      wsrc_q   <= wsrc_d;
      wdst_q   <= wdst_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      ie_q     <= ie_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Host port driven from registered state; quiet (all zero) when not requesting
  assign host_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign host_we_o    = (state_q == WR_REQ);
  assign host_be_o    = host_req_o ? 4'hF : 4'h0;
  assign host_addr_o  = (state_q == RD_REQ) ? wsrc_q :
                        (state_q == WR_REQ) ? wdst_q : '0;
  assign host_wdata_o = (state_q == WR_REQ) ? data_q : '0;

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_err_o    = rerr_q;
  assign cfg_rdata_o  = rdata_q;
  assign dma_intr_o   = done_q & ie_q;

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: directed and randomized copies against a RAM responder and a
// word-level copy model; register-port behaviour checked with constants.
module tb_dma_copy;

  localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08;
  localparam logic [31:0] A_CTRL = 32'h0C, A_STATUS = 32'h10;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cfg_req, cfg_we;
  logic [3:0]  cfg_be;
  logic [31:0] cfg_addr, cfg_wdata;
  logic        cfg_rvalid, cfg_err;
  logic [31:0] cfg_rdata;
  logic        host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic [3:0]  host_be;
  logic        intr;

  dma_copy dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_be_i(cfg_be),
    .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .host_req_o(host_req), .host_gnt_i(host_gnt), .host_addr_o(host_addr),
    .host_we_o(host_we), .host_be_o(host_be), .host_wdata_o(host_wdata),
    .host_rvalid_i(host_rvalid), .host_rdata_i(host_rdata), .host_err_i(host_err),
    .dma_intr_o(intr)
  );

  int errors = 0, checks = 0;
  int viol_idle = 0, viol_stable = 0, viol_cfg = 0;
  int gnt_delay = 0, rsp_min = 0, rsp_max = 0, err_read = 0;
  int read_count = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  txn_t log_q[$];
  txn_t exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a);
  endfunction

  // RAM responder: grant after gnt_delay waiting cycles, answer after a random delay
  initial begin
    logic [31:0] cap_addr, cap_wdata, p_data;
    logic        cap_we, p_err, pending;
    int          waitc, resp_wait;
    txn_t        t;
    host_gnt = 0; host_rvalid = 0; host_err = 0; host_rdata = 0;
    pending = 0; waitc = 0; resp_wait = 0; p_err = 0; p_data = 0;
    cap_addr = 0; cap_wdata = 0; cap_we = 0;
    forever begin
      @(negedge clk);
      host_gnt = 0; host_rvalid = 0; host_err = 0; host_rdata = 0;
      if (!host_req && (host_addr != 0 || host_we || host_be != 0 || host_wdata != 0))
        viol_idle++;
      if (pending) begin
        if (resp_wait == 0) begin
          host_rvalid = 1; host_err = p_err; host_rdata = p_data; pending = 0;
        end else resp_wait--;
      end else if (host_req) begin
        if (waitc == 0) begin
          cap_addr = host_addr; cap_we = host_we; cap_wdata = host_wdata;
        end else if (cap_addr != host_addr || cap_we != host_we || cap_wdata != host_wdata)
          viol_stable++;
        if (host_be != 4'hF) viol_stable++;
        if (waitc < gnt_delay) waitc++;
        else begin
          waitc = 0;
          host_gnt = 1;
          t.we = host_we; t.addr = host_addr;
          if (host_we) begin
            mem[host_addr] = host_wdata;
            t.data = host_wdata; p_err = 0; p_data = 0;
          end else begin
            read_count++;
            p_err  = (read_count == err_read);
            p_data = p_err ? 32'h0 : mem_rd(host_addr);
            t.data = p_data;
          end
          log_q.push_back(t);
          pending = 1;
          resp_wait = $urandom_range(rsp_max, rsp_min);
        end
      end
    end
  end

  task automatic cfg(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    cfg_req = 1; cfg_we = we; cfg_be = be; cfg_addr = addr; cfg_wdata = wdata;
    @(negedge clk);
    if (cfg_rvalid !== 1'b1) viol_cfg++;
    rdata = cfg_rdata; err = cfg_err;
    cfg_req = 0; cfg_we = 0; cfg_be = 0; cfg_addr = 0; cfg_wdata = 0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d; logic e;
    cfg(1'b1, addr, 4'hF, data, d, e);
    if (e !== 1'b0 || d !== 32'h0) viol_cfg++;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic e;
    cfg(1'b0, addr, 4'h0, 32'h0, data, e);
    if (e !== 1'b0) viol_cfg++;
  endtask

  int log_base = 0;

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input logic ie, input int err_at);
    log_base = log_q.size();
    exp_q.delete();
    err_read = (err_at == 0) ? 0 : read_count + err_at;
    wr(A_SRC, s);
    wr(A_DST, d);
    wr(A_LEN, 32'(n));
    wr(A_CTRL, 32'({ie, 1'b1}));
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    bit idle = 0;
    for (int i = 0; i < 500; i++) begin
      rd(A_STATUS, s);
      if (!s[0]) begin idle = 1; break; end
    end
    check({tag, "_idle"}, 128'(idle), 128'(1));
  endtask

  // Reference: sequential word copies, one read then one write per word
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int err_at);
    txn_t t;
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      if (i + 1 == err_at) begin
        t.we = 0; t.addr = s + 32'(4 * i); t.data = 0; exp_q.push_back(t);
        break;
      end
      v = model_rd(s + 32'(4 * i));
      t.we = 0; t.addr = s + 32'(4 * i); t.data = v; exp_q.push_back(t);
      t.we = 1; t.addr = d + 32'(4 * i); t.data = v; exp_q.push_back(t);
      model_mem[d + 32'(4 * i)] = v;
    end
  endtask

  task automatic finish_xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                             input int n, input int err_at);
    logic [31:0] st;
    wait_idle(tag);
    model_copy(s, d, n, err_at);
    check({tag, "_ntxn"}, 128'(log_q.size() - log_base), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++)
      check({tag, "_txn"}, 128'(log_q[log_base + i]), 128'(exp_q[i]));
    rd(A_STATUS, st);
    check({tag, "_status"}, 128'(st), (err_at != 0) ? 128'(6) : 128'(2));
    for (int i = 0; i < n; i++)
      check({tag, "_mem"}, 128'(mem_rd(d + 32'(4 * i))), 128'(model_rd(d + 32'(4 * i))));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, s, dd;
    logic        e;
    int          n, req_hi;
    bit          seen;

    rst = 1; cfg_req = 0; cfg_we = 0; cfg_be = 0; cfg_addr = 0; cfg_wdata = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("reset_outputs", 128'({host_req, host_we, host_be, host_addr, host_wdata,
                                 cfg_rvalid, cfg_err, cfg_rdata, intr}), 128'(0));
    rd(A_STATUS, d); check("reset_status", 128'(d), 128'(0));
    rd(A_SRC, d);    check("reset_src", 128'(d), 128'(0));

    // Register access: low-bit forcing, byte enables, LEN width, errors
    wr(A_SRC, 32'h12345677);
    rd(A_SRC, d); check("src_align", 128'(d), 128'(32'h12345674));
    cfg(1'b1, A_SRC, 4'b0011, 32'hAAAABBBB, d, e);
    rd(A_SRC, d); check("src_be", 128'(d), 128'(32'h1234BBB8));
    wr(A_LEN, 32'h00010005);
    rd(A_LEN, d); check("len_width", 128'(d), 128'(32'h5));
    wr(A_CTRL, 32'h2);
    rd(A_CTRL, d); check("ctrl_ie", 128'(d), 128'(32'h2));
    cfg(1'b0, 32'h14, 4'h0, 32'h0, d, e);
    check("unmapped_rd", 128'({e, d}), 128'({1'b1, 32'h0}));
    cfg(1'b1, 32'h1C, 4'hF, 32'hFFFFFFFF, d, e);
    check("unmapped_wr_err", 128'(e), 128'(1));
    rd(A_SRC, d); check("unmapped_no_change", 128'(d), 128'(32'h1234BBB8));

    // LEN=0: no host traffic, DONE (and so the interrupt) one cycle after START
    start_xfer(32'h0, 32'h0, 16'd0, 1'b1, 0);
    check("len0_intr", 128'(intr), 128'(1));
    rd(A_STATUS, d); check("len0_status", 128'(d), 128'(2));
    check("len0_no_host", 128'(log_q.size() - log_base), 128'(0));
    wr(A_STATUS, 32'h2); wr(A_CTRL, 32'h0);

    // Basic copy with zero-wait RAM
    gnt_delay = 0; rsp_min = 0; rsp_max = 0;
    start_xfer(32'h00100000, 32'h00100100, 16'd3, 1'b0, 0);
    finish_xfer("basic", 32'h00100000, 32'h00100100, 3, 0);

    // Delayed grants; programming writes while busy must be ignored
    gnt_delay = 4; rsp_min = 0; rsp_max = 2;
    start_xfer(32'h00200000, 32'h00208000, 16'd3, 1'b0, 0);
    wr(A_SRC, 32'hDEAD0000);
    wr(A_LEN, 32'h77);
    wr(A_CTRL, 32'h1);
    finish_xfer("gntdly", 32'h00200000, 32'h00208000, 3, 0);
    rd(A_SRC, d); check("busy_src_kept", 128'(d), 128'(32'h00200000));
    rd(A_LEN, d); check("busy_len_kept", 128'(d), 128'(3));

    // Error on the second read aborts after one write
    gnt_delay = 1; rsp_min = 0; rsp_max = 1;
    start_xfer(32'h00300000, 32'h00310000, 16'd4, 1'b0, 2);
    finish_xfer("rderr", 32'h00300000, 32'h00310000, 4, 2);
    err_read = 0;

    // Interrupt on completion, cleared by W1C of DONE
    gnt_delay = 0;
    start_xfer(32'h00400000, 32'h00400040, 16'd1, 1'b1, 0);
    finish_xfer("intr", 32'h00400000, 32'h00400040, 1, 0);
    check("intr_set", 128'(intr), 128'(1));
    wr(A_STATUS, 32'h2);
    check("intr_clr", 128'(intr), 128'(0));
    rd(A_CTRL, d); check("ctrl_start_reads0", 128'(d), 128'(2));
    wr(A_CTRL, 32'h0);

    // Address wrap at the top of the address space
    start_xfer(32'hFFFFFFFC, 32'h00003000, 16'd2, 1'b0, 0);
    finish_xfer("wrap", 32'hFFFFFFFC, 32'h00003000, 2, 0);

    // Randomized copies
    for (int t = 0; t < 4; t++) begin
      s  = 32'h20000000 + (32'($urandom_range(63, 0)) << 2);
      dd = 32'h20001000 + (32'($urandom_range(63, 0)) << 2);
      n  = $urandom_range(6, 1);
      gnt_delay = $urandom_range(3, 0); rsp_min = 0; rsp_max = 2;
      start_xfer(s, dd, 16'(n), 1'b0, 0);
      finish_xfer("rand", s, dd, n, 0);
    end

    // Reset during WR_WAIT: transfer abandoned, late response ignored
    gnt_delay = 0; rsp_min = 6; rsp_max = 6;
    start_xfer(32'h00004000, 32'h00005000, 16'd2, 1'b0, 0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (log_q.size() - log_base >= 2) begin seen = 1; break; end
    end
    check("rst_wr_granted", 128'(seen), 128'(1));
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    req_hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (host_req) req_hi++;
    end
    check("rst_no_req", 128'(req_hi), 128'(0));
    check("rst_no_txn", 128'(log_q.size() - log_base), 128'(2));
    check("rst_outputs", 128'({host_req, host_addr, host_wdata, intr}), 128'(0));
    rd(A_STATUS, d); check("rst_status", 128'(d), 128'(0));
    rd(A_SRC, d);    check("rst_src", 128'(d), 128'(0));

    check("idle_outputs_zero", 128'(viol_idle), 128'(0));
    check("req_stable", 128'(viol_stable), 128'(0));
    check("cfg_response", 128'(viol_cfg), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
